// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution output collector:
//   - conv_state_t : collector FSM states (IDLE / WAIT / COLLECT)
//   - TREE_W       : width of one signed tree result
//   - PIX_W        : width of one requantised output pixel
//   - clog2()      : counter-width helper usable in parameter expressions
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int TREE_W = 32;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2
    } conv_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// -----------------------------------------------------------------------------
// requant_sat
// Single-lane combinational requantiser: ReLU, arithmetic right shift by SHIFT,
// then unsigned saturation to one output pixel.
// Ports:
//   i_value  in  TREE_W  signed tree result
//   o_pixel  out PIX_W   requantised pixel (0..255)
// -----------------------------------------------------------------------------
module requant_sat
    import conv_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic [TREE_W-1:0] i_value,
    output logic [PIX_W-1:0]  o_pixel
);

    logic [TREE_W-1:0] w_shifted;

    // Only non-negative values reach the shifter output, so a logical shift is exact.
    assign w_shifted = i_value >> SHIFT;

    // ReLU first, then clamp anything that does not fit in one pixel.
    always_comb begin
        o_pixel = {PIX_W{1'b0}};
        if (i_value[TREE_W-1]) begin
            o_pixel = {PIX_W{1'b0}};
        end else if (|w_shifted[TREE_W-1:PIX_W]) begin
            o_pixel = {PIX_W{1'b1}};
        end else begin
            o_pixel = w_shifted[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv_output_collector.sv
// -----------------------------------------------------------------------------
// conv_output_collector
// Sink for the free-running output of a convolution layer. After `start`, waits
// LATENCY cycles for window 0, then walks the window top-left (row, col) over
// the image, keeps only windows that do not wrap a row edge, requantises each
// lane and presents it with out_valid; frame_done marks the last result.
// Ports:
//   clock             in   1               rising-edge clock
//   reset             in   1               asynchronous, active-low
//   start             in   1               pixel 0 enters the layer (also aborts)
//   pixel_vector_in   in   32*NUM_TREES    signed tree results, lane n at [32n+:32]
//   pixel_vector_out  out  8*NUM_TREES     requantised results, lane n at [8n+:8]
//   out_valid         out  1               pixel_vector_out holds a window result
//   frame_done        out  1               coincident with last out_valid of frame
//   busy              out  1               frame in progress (WAIT or COLLECT)
// -----------------------------------------------------------------------------
module conv_output_collector
    import conv_pkg::*;
#(
    parameter int NUM_TREES  = 2,
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6,
    parameter int KERNEL_DIM = 4,
    parameter int LATENCY    = 27,
    parameter int SHIFT      = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [TREE_W*NUM_TREES-1:0] pixel_vector_in,
    output logic [PIX_W*NUM_TREES-1:0]  pixel_vector_out,
    output logic                        out_valid,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int DLY_W = clog2(LATENCY) + 1;
    localparam int COL_W = clog2(IMG_WIDTH) + 1;
    localparam int ROW_W = clog2(IMG_HEIGHT) + 1;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(LATENCY - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_VMAX = COL_W'(IMG_WIDTH - KERNEL_DIM);
    localparam logic [ROW_W-1:0] ROW_VMAX = ROW_W'(IMG_HEIGHT - KERNEL_DIM);

    conv_state_t                  r_state;
    logic [DLY_W-1:0]             r_dly;
    logic [COL_W-1:0]             r_col;
    logic [ROW_W-1:0]             r_row;
    logic [PIX_W*NUM_TREES-1:0]   r_pix_out;
    logic                         r_out_valid;
    logic                         r_frame_done;
    logic                         r_busy;

    conv_state_t                  w_state_nxt;
    logic [DLY_W-1:0]             w_dly_nxt;
    logic [COL_W-1:0]             w_col_nxt;
    logic [ROW_W-1:0]             w_row_nxt;
    logic [COL_W-1:0]             w_col_adv;
    logic [ROW_W-1:0]             w_row_adv;
    logic                         w_sample;
    logic                         w_win_valid;
    logic                         w_last;
    logic [PIX_W*NUM_TREES-1:0]   w_pix;

    // One requantiser per kernel-tree lane.
    for (genvar g = 0; g < NUM_TREES; g++) begin : g_lane
        requant_sat #(
            .SHIFT (SHIFT)
        ) u_requant (
            .i_value (pixel_vector_in[TREE_W*g +: TREE_W]),
            .o_pixel (w_pix[PIX_W*g +: PIX_W])
        );
    end

    // The final WAIT cycle (counter at 0) already holds window 0, so it counts
    // as the first sample; this keeps window 0 at exactly start+LATENCY even
    // for LATENCY = 1.
    assign w_sample    = (r_state == ST_COLLECT) ||
                         ((r_state == ST_WAIT) && (r_dly == {DLY_W{1'b0}}));
    assign w_win_valid = (r_col <= COL_VMAX);
    assign w_last      = w_sample && (r_row == ROW_VMAX) && (r_col == COL_VMAX);

    // Raster advance of the window top-left position.
    always_comb begin
        w_col_adv = r_col + COL_W'(1);
        w_row_adv = r_row;
        if (r_col == COL_LAST) begin
            w_col_adv = {COL_W{1'b0}};
            w_row_adv = r_row + ROW_W'(1);
        end else begin
            w_col_adv = r_col + COL_W'(1);
            w_row_adv = r_row;
        end
    end

    // Next-state logic; start has priority and restarts the frame from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (start) begin
            w_state_nxt = ST_WAIT;
            w_dly_nxt   = DLY_LOAD;
            w_col_nxt   = {COL_W{1'b0}};
            w_row_nxt   = {ROW_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_WAIT, ST_COLLECT: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_sample) begin
                        w_state_nxt = ST_COLLECT;
                        w_col_nxt   = w_col_adv;
                        w_row_nxt   = w_row_adv;
                    end else begin
                        w_dly_nxt   = r_dly - DLY_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, delay counter and window position registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dly   <= {DLY_W{1'b0}};
            r_col   <= {COL_W{1'b0}};
            r_row   <= {ROW_W{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Output registers; the pixel bus only updates on valid windows so it holds
    // its last result otherwise. A sample taken together with start is still
    // emitted, which is how the last sample of a back-to-back frame survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pix_out    <= {(PIX_W*NUM_TREES){1'b0}};
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_sample && w_win_valid;
            r_frame_done <= w_last;
            if (w_sample && w_win_valid) begin
                r_pix_out <= w_pix;
            end else begin
                r_pix_out <= r_pix_out;
            end
        end
    end

    assign pixel_vector_out = r_pix_out;
    assign out_valid        = r_out_valid;
    assign frame_done       = r_frame_done;
    assign busy             = r_busy;

endmodule

// File: tb/tb_conv_output_collector.sv
// -----------------------------------------------------------------------------
// tb_conv_output_collector
// Directed bench for conv_output_collector with default geometry. Two
// instances share all inputs: dut0 with SHIFT=0 and dut1 with SHIFT=1.
// A negedge monitor logs every out_valid of dut0 with its cycle number.
// -----------------------------------------------------------------------------
module tb_conv_output_collector;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] pvi;
    logic [15:0] pvo0, pvo1;
    logic        ov0, ov1, fd0, fd1, busy0, busy1;

    int n_checks;
    int n_errors;
    int cyc;
    int ramp_base;
    bit ramp_on;

    int         mon_n;
    int         mon_done_n;
    logic [7:0] mon_val  [0:255];
    int         mon_t    [0:255];
    logic       mon_fd   [0:255];
    logic       mon_busy [0:255];

    conv_output_collector #(
        .NUM_TREES(2), .IMG_WIDTH(6), .IMG_HEIGHT(6),
        .KERNEL_DIM(4), .LATENCY(27), .SHIFT(0)
    ) dut0 (
        .clock(clock), .reset(reset), .start(start),
        .pixel_vector_in(pvi), .pixel_vector_out(pvo0),
        .out_valid(ov0), .frame_done(fd0), .busy(busy0)
    );

    conv_output_collector #(
        .NUM_TREES(2), .IMG_WIDTH(6), .IMG_HEIGHT(6),
        .KERNEL_DIM(4), .LATENCY(27), .SHIFT(1)
    ) dut1 (
        .clock(clock), .reset(reset), .start(start),
        .pixel_vector_in(pvi), .pixel_vector_out(pvo1),
        .out_valid(ov1), .frame_done(fd1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter: value seen during a cycle is the number of the cycle.
    always @(posedge clock) cyc <= cyc + 1;

    // Log dut0 results away from the active edge.
    always @(negedge clock) begin
        if (ov0 && mon_n < 256) begin
            mon_val[mon_n]  <= pvo0[7:0];
            mon_t[mon_n]    <= cyc;
            mon_fd[mon_n]   <= fd0;
            mon_busy[mon_n] <= busy0;
            mon_n           <= mon_n + 1;
        end
        if (fd0) begin
            mon_done_n <= mon_done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (ramp_on) begin
            pvi[31:0]  = 32'(cyc - ramp_base);
            pvi[63:32] = 32'd0;
        end
    endtask

    // Sample index of the j-th valid window (6 columns, 3 valid per row).
    function automatic int exp_idx(input int j);
        return (j / 3) * 6 + (j % 3);
    endfunction

    // Check nine logged results of one ramp frame started in cycle s.
    task automatic check_frame(input int base, input int s, input logic busy_at_done);
        for (int j = 0; j < 9; j++) begin
            check("ramp_val", 32'(mon_val[base + j]), 32'(exp_idx(j)));
            check("ramp_time", 32'(mon_t[base + j]), 32'(s + 28 + exp_idx(j)));
            check("ramp_done", 32'(mon_fd[base + j]), 32'(j == 8));
        end
        check("busy_at_done", 32'(mon_busy[base + 8]), 32'(busy_at_done));
    endtask

    initial begin
        int s, s2, v0, d0, k, old_n;
        bit busy_drop;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        mon_n      = 0;
        mon_done_n = 0;
        ramp_on    = 1'b0;
        ramp_base  = 0;
        reset      = 1'b0;
        start      = 1'b0;
        pvi        = 64'd0;

        // Reset state
        repeat (3) step();
        check("rst_pvo0", 32'(pvo0), 32'd0);
        check("rst_valid", 32'(ov0), 32'd0);
        check("rst_done", 32'(fd0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_busy", 32'(busy0), 32'd0);

        // Ramp frame: nine outputs 0,1,2,6,7,8,12,13,14 from start+28
        v0 = mon_n; d0 = mon_done_n;
        start = 1'b1; s = cyc; ramp_base = s + 27; ramp_on = 1'b1;
        step();
        start = 1'b0;
        check("busy_rise", 32'(busy0), 32'd1);
        while (cyc < s + 46) step();
        check("ramp_count", 32'(mon_n - v0), 32'd9);
        check("ramp_frames", 32'(mon_done_n - d0), 32'd1);
        check_frame(v0, s, 1'b0);
        check("ramp_busy_end", 32'(busy0), 32'd0);

        // Saturation, ReLU and hold, checked on both shift settings
        ramp_on = 1'b0; pvi = 64'd0;
        d0 = mon_done_n;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        while (cyc < s + 32) begin
            step();
            if (cyc == s + 27) pvi = {32'd412, 32'd252};
            if (cyc == s + 28) begin
                check("sat_valid", 32'(ov0), 32'd1);
                check("sat_sh0", 32'(pvo0), 32'h0000FFFC);
                check("sat_sh1", 32'(pvo1), 32'h0000CE7E);
                pvi = {32'h0000_0100, 32'hFFFF_FF00};
            end
            if (cyc == s + 29) begin
                check("relu_sh0", 32'(pvo0), 32'h0000FF00);
                check("relu_sh1", 32'(pvo1), 32'h00008000);
                pvi = {32'd5, 32'd7};
            end
            if (cyc == s + 30) begin
                check("plain_val", 32'(pvo0), 32'h00000507);
                pvi = {32'd99, 32'd99};
            end
            if (cyc == s + 31) begin
                check("edge_invalid", 32'(ov0), 32'd0);
                check("edge_hold", 32'(pvo0), 32'h00000507);
            end
        end
        while (cyc < s + 46) step();
        check("sat_frames", 32'(mon_done_n - d0), 32'd1);
        check("sat_busy_end", 32'(busy0), 32'd0);

        // Abort after four valid outputs
        v0 = mon_n; d0 = mon_done_n;
        start = 1'b1; s = cyc; ramp_base = s + 27; ramp_on = 1'b1;
        step();
        start = 1'b0;
        while (cyc < s + 34) step();
        start = 1'b1; s2 = cyc;
        step();
        start = 1'b0; ramp_base = s2 + 27;
        while (cyc < s2 + 46) step();
        old_n = 0; k = mon_n;
        for (int i = v0; i < mon_n; i++) begin
            if (mon_t[i] <= s2 + 1) old_n++;
            else if (k == mon_n) k = i;
        end
        check("abort_old_ge4", 32'(old_n >= 4), 32'd1);
        check("abort_new_count", 32'(mon_n - k), 32'd9);
        check("abort_frames", 32'(mon_done_n - d0), 32'd1);
        if (mon_n - k == 9) check_frame(k, s2, 1'b0);

        // Reset in the middle of COLLECT
        v0 = mon_n;
        start = 1'b1; s = cyc; ramp_base = s + 27;
        step();
        start = 1'b0;
        while (cyc < s + 30) step();
        reset = 1'b0;
        #1;
        check("mid_rst_pvo", 32'(pvo0), 32'd0);
        check("mid_rst_valid", 32'(ov0), 32'd0);
        check("mid_rst_done", 32'(fd0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        step(); step();
        reset = 1'b1;
        v0 = mon_n;
        repeat (40) step();
        check("post_rst_quiet", 32'(mon_n - v0), 32'd0);
        check("post_rst_busy", 32'(busy0), 32'd0);

        // Back-to-back frames with start on the last sample
        v0 = mon_n; d0 = mon_done_n; busy_drop = 1'b0;
        start = 1'b1; s = cyc; ramp_base = s + 27;
        step();
        start = 1'b0;
        while (cyc < s + 41) begin
            if (!busy0) busy_drop = 1'b1;
            step();
        end
        start = 1'b1; s2 = cyc;
        step();
        start = 1'b0; ramp_base = s2 + 27;
        while (cyc < s2 + 46) begin
            if (cyc <= s2 + 41 && !busy0) busy_drop = 1'b1;
            step();
        end
        check("b2b_busy_cont", 32'(busy_drop), 32'd0);
        check("b2b_count", 32'(mon_n - v0), 32'd18);
        check("b2b_frames", 32'(mon_done_n - d0), 32'd2);
        check_frame(v0, s, 1'b1);
        check_frame(v0 + 9, s2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
